// File: rtl/dsm_pkg.sv
// -----------------------------------------------------------------------------
// dsm_pkg
// Shared types and constants for the second-order delta-sigma modulator.
//   dsm_state_t : modulator state (IDLE=0, RUN=1, RECOVER=2)
//   FB          : feedback magnitude, full scale of the Q1.14 mixer sample
//   LFSR_SEED   : reset value of the optional dither LFSR
//   LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
// -----------------------------------------------------------------------------
package dsm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } dsm_state_t;

  localparam int FB = 16384;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dsm_sat_add.sv
// -----------------------------------------------------------------------------
// dsm_sat_add
// Combinational signed adder whose result is clamped to the DATA_W range
// instead of wrapping.
//   a, b : signed addends (DATA_W)
//   sum  : saturated signed sum (DATA_W)
// -----------------------------------------------------------------------------
module dsm_sat_add #(
  parameter int DATA_W = 20
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] sum
);

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  // One guard bit is enough for a two-operand sum; disagreement between the
  // guard bit and the result MSB means the true sum left the range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1]) begin
      return v[DATA_W] ? MIN_V : MAX_V;
    end
    return v[DATA_W-1:0];
  endfunction

  logic signed [DATA_W:0] wide;

  assign wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign sum  = sat(wide);

endmodule

// File: rtl/dsm2_modulator.sv
// -----------------------------------------------------------------------------
// dsm2_modulator
// Second-order 1-bit delta-sigma modulator (Boser-Wooley: two half-gain
// saturating integrators and a sign quantizer) with overload detection and
// automatic integrator-reset recovery.
//   clock, reset : clock and synchronous active-high reset
//   enable       : 0 holds the modulator cleared in IDLE
//   in_valid     : sample strobe, mix_i is accepted when high
//   mix_i        : signed Q1.14 input sample
//   ovl_clr      : clears ovl_sticky (a simultaneous RECOVER entry wins)
//   dout         : bitstream bit, 1 = +FB, 0 = -FB
//   dout_valid   : one-cycle pulse in the cycle after each accepted strobe
//   ovl_sticky   : set whenever RECOVER is entered
//   state_o      : IDLE=0, RUN=1, RECOVER=2
// Optional feature: define DSM2_DITHER_EN to add a 16-bit LFSR dither term
// (-8..+7) to the quantizer decision. Without it the bitstream is fully
// deterministic.
// -----------------------------------------------------------------------------
module dsm2_modulator
  import dsm_pkg::*;
#(
  parameter int IN_W        = 15,
  parameter int ACC_W       = 20,
  parameter int OVL_THRESH  = 262144,
  parameter int OVL_LIMIT   = 8,
  parameter int RECOVER_LEN = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   in_valid,
  input  logic signed [IN_W-1:0] mix_i,
  input  logic                   ovl_clr,
  output logic                   dout,
  output logic                   dout_valid,
  output logic                   ovl_sticky,
  output logic [1:0]             state_o
);

  localparam int OC_W = $clog2(OVL_LIMIT + 1);
  localparam int RC_W = $clog2(RECOVER_LEN + 1);

  localparam logic signed [ACC_W-1:0] FB_POS  = ACC_W'(FB);
  localparam logic signed [ACC_W-1:0] FB_NEG  = ACC_W'(-FB);
  localparam logic signed [ACC_W-1:0] OVL_POS = ACC_W'(OVL_THRESH);
  localparam logic signed [ACC_W-1:0] OVL_NEG = ACC_W'(-OVL_THRESH);

  // (a - b) >>> 1 evaluated one bit wider so the difference cannot wrap;
  // after the halving the result always fits back into ACC_W.
  function automatic logic signed [ACC_W-1:0] half_diff(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] d;
    d = {a[ACC_W-1], a} - {b[ACC_W-1], b};
    return ACC_W'(d >>> 1);
  endfunction

  dsm_state_t              state;
  logic signed [ACC_W-1:0] int1;
  logic signed [ACC_W-1:0] int2;
  logic                    q;
  logic                    vld_p1;
  logic                    sticky;
  logic [OC_W-1:0]         ovl_cnt;
  logic [RC_W-1:0]         rec_cnt;

  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] fb;
  logic signed [ACC_W-1:0] step1;
  logic signed [ACC_W-1:0] step2;
  logic signed [ACC_W-1:0] int1_next;
  logic signed [ACC_W-1:0] int2_next;
  logic                    q_next;
  logic                    ovl_hit;
  logic                    enter_rec;

  assign x     = {{(ACC_W-IN_W){mix_i[IN_W-1]}}, mix_i};
  assign fb    = q ? FB_POS : FB_NEG;
  assign step1 = half_diff(x, fb);
  assign step2 = half_diff(int1, fb);

  dsm_sat_add #(.DATA_W(ACC_W)) u_int1 (
    .a   (int1),
    .b   (step1),
    .sum (int1_next)
  );

  dsm_sat_add #(.DATA_W(ACC_W)) u_int2 (
    .a   (int2),
    .b   (step2),
    .sum (int2_next)
  );

`ifdef DSM2_DITHER_EN
  logic [15:0]             lfsr;
  logic signed [4:0]       dith5;
  logic signed [ACC_W-1:0] dith;
  logic signed [ACC_W:0]   qsum;

  assign dith5  = $signed({1'b0, lfsr[3:0]}) - 5'sd8;
  assign dith   = {{(ACC_W-5){dith5[4]}}, dith5};
  assign qsum   = {int2_next[ACC_W-1], int2_next} + {dith[ACC_W-1], dith};
  assign q_next = ~qsum[ACC_W];
`else
  assign q_next = ~int2_next[ACC_W-1];
`endif

  assign ovl_hit   = (int2_next >= OVL_POS) || (int2_next <= OVL_NEG);
  assign enter_rec = enable && (state == RUN) && in_valid && ovl_hit &&
                     (ovl_cnt == OC_W'(OVL_LIMIT - 1));

  // ---- stage p0 -> p1: integrators, quantizer, control ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      int1    <= '0;
      int2    <= '0;
      q       <= 1'b0;
      vld_p1  <= 1'b0;
      sticky  <= 1'b0;
      ovl_cnt <= '0;
      rec_cnt <= '0;
`ifdef DSM2_DITHER_EN
      lfsr    <= LFSR_SEED;
`endif
    end else begin
      vld_p1 <= 1'b0;

      if (enter_rec) begin
        sticky <= 1'b1;
      end else if (ovl_clr) begin
        sticky <= 1'b0;
      end

      if (!enable) begin
        state   <= IDLE;
        int1    <= '0;
        int2    <= '0;
        q       <= 1'b0;
        ovl_cnt <= '0;
        rec_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Strobes arriving while leaving IDLE are dropped on purpose.
            state <= RUN;
          end
          RUN: begin
            if (in_valid) begin
              vld_p1 <= 1'b1;
              q      <= q_next;
`ifdef DSM2_DITHER_EN
              lfsr   <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
`endif
              if (enter_rec) begin
                state   <= RECOVER;
                int1    <= '0;
                int2    <= '0;
                ovl_cnt <= '0;
              end else begin
                int1    <= int1_next;
                int2    <= int2_next;
                ovl_cnt <= ovl_hit ? ovl_cnt + 1'b1 : '0;
              end
            end
          end
          RECOVER: begin
            if (in_valid) begin
              vld_p1 <= 1'b1;
              if (rec_cnt == RC_W'(RECOVER_LEN - 1)) begin
                rec_cnt <= '0;
                q       <= 1'b0;
                state   <= RUN;
              end else begin
                rec_cnt <= rec_cnt + 1'b1;
                // Alternating 1,0,1,0... keyed off the strobe index.
                q       <= ~rec_cnt[0];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dout       = q;
  assign dout_valid = vld_p1;
  assign ovl_sticky = sticky;
  assign state_o    = state;

endmodule

// File: tb/tb_dsm2_modulator.sv
// -----------------------------------------------------------------------------
// tb_dsm2_modulator
// Directed bench for dsm2_modulator. Two instances share the stimulus: dut
// uses the default parameters, dut_ovl lowers OVL_THRESH to 4096 so the
// overload/recovery path can be reached with a full-scale input.
// -----------------------------------------------------------------------------
module tb_dsm2_modulator;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               in_valid;
  logic signed [14:0] mix_i;
  logic               ovl_clr;

  logic               dout;
  logic               dout_valid;
  logic               ovl_sticky;
  logic [1:0]         state_o;

  logic               o_dout;
  logic               o_dout_valid;
  logic               o_sticky;
  logic [1:0]         o_state;

  int checks   = 0;
  int failures = 0;

  // Zero-input start-up, hand-computed: (int1, int2, bit) after samples 1..8.
  int exp_int1 [8] = '{8192, 0, -8192, 0, -8192, 0, 8192, 0};
  int exp_int2 [8] = '{8192, 4096, -4096, 0, -8192, -4096, 4096, 0};
  int exp_bit  [8] = '{1, 1, 0, 1, 0, 0, 1, 1};

  always #5 clock = ~clock;

  dsm2_modulator dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .mix_i      (mix_i),
    .ovl_clr    (ovl_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ovl_sticky (ovl_sticky),
    .state_o    (state_o)
  );

  dsm2_modulator #(.OVL_THRESH(4096)) dut_ovl (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .in_valid   (in_valid),
    .mix_i      (mix_i),
    .ovl_clr    (ovl_clr),
    .dout       (o_dout),
    .dout_valid (o_dout_valid),
    .ovl_sticky (o_sticky),
    .state_o    (o_state)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset both instances and step them into RUN with q=0 and cleared integrators.
  task automatic restart();
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    ovl_clr  = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("restart_state", int'(state_o), 1);
  endtask

  task automatic density(input int mix, input int lo, input int hi, input string tag);
    int ones;
    ones = 0;
    restart();
    mix_i    = 15'(mix);
    in_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones += int'(dout);
    end
    in_valid = 1'b0;
    check(tag, int'(ones >= lo && ones <= hi), 1);
    if (ones < lo || ones > hi) $display("  ones=%0d window=[%0d,%0d]", ones, lo, hi);
  endtask

  initial begin
    int ones;
    int nvalid;

    // 1: reset held with strobes active
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    ovl_clr  = 1'b0;
    mix_i    = 15'sd8192;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_dout",   int'(dout),       0);
      check("rst_dvalid", int'(dout_valid), 0);
      check("rst_sticky", int'(ovl_sticky), 0);
      check("rst_state",  int'(state_o),    0);
    end

    // 2: zero-input start-up, strobe every cycle
    reset = 1'b0;
    mix_i = '0;
    tick();
    check("t2_enter_run", int'(state_o),    1);
    check("t2_ignored",   int'(dout_valid), 0);
    ones   = 0;
    nvalid = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      ones   += int'(dout);
      nvalid += int'(dout_valid);
      if (i < 8) check($sformatf("t2_bit%0d", i), int'(dout), exp_bit[i]);
      if (i == 1) begin
        check("t2_int1", int'(dut.int1), 0);
        check("t2_int2", int'(dut.int2), 4096);
      end
    end
    in_valid = 1'b0;
    check("t2_nvalid", nvalid, 1024);
    check("t2_density", int'(ones >= 510 && ones <= 514), 1);

    // 3: DC at +/- half scale
    density(8192,  3031, 3113, "t3_pos_density");
    density(-8192,  983, 1065, "t3_neg_density");

    // 4: strobe every 4th cycle
    restart();
    mix_i = '0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("t4_dv%0d", k),   int'(dout_valid), 1);
      check($sformatf("t4_bit%0d", k),  int'(dout),       exp_bit[k]);
      check($sformatf("t4_int1_%0d", k), int'(dut.int1),  exp_int1[k]);
      check($sformatf("t4_int2_%0d", k), int'(dut.int2),  exp_int2[k]);
      for (int g = 0; g < 3; g++) begin
        tick();
        check($sformatf("t4_gap_dv%0d_%0d", k, g),   int'(dout_valid), 0);
        check($sformatf("t4_gap_int1_%0d_%0d", k, g), int'(dut.int1),  exp_int1[k]);
        check($sformatf("t4_gap_int2_%0d_%0d", k, g), int'(dut.int2),  exp_int2[k]);
      end
    end

    // 5: overload on dut_ovl (int2 >= 4096 on samples 1..8 for +16383)
    restart();
    mix_i    = 15'sd16383;
    in_valid = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      ovl_clr = (s == 8);
      tick();
      check($sformatf("t5_bit%0d", s),   int'(o_dout),  1);
      check($sformatf("t5_state%0d", s), int'(o_state), (s < 8) ? 1 : 2);
    end
    check("t5_sticky_set_wins", int'(o_sticky), 1);
    check("t5_int1_clr", int'(dut_ovl.int1), 0);
    check("t5_int2_clr", int'(dut_ovl.int2), 0);
    for (int r = 0; r < 16; r++) begin
      ovl_clr = (r == 0);
      tick();
      check($sformatf("t5_rec_dv%0d", r),    int'(o_dout_valid), 1);
      check($sformatf("t5_rec_bit%0d", r),   int'(o_dout),       (r % 2 == 0) ? 1 : 0);
      check($sformatf("t5_rec_state%0d", r), int'(o_state),      (r < 15) ? 2 : 1);
      check($sformatf("t5_rec_int2_%0d", r), int'(dut_ovl.int2), 0);
      if (r == 0) check("t5_sticky_clr", int'(o_sticky), 0);
    end
    ovl_clr = 1'b0;

    // 6: re-enter RECOVER, then drop enable mid-RECOVER
    for (int s = 1; s <= 8; s++) tick();
    check("t6_in_recover", int'(o_state), 2);
    for (int r = 0; r < 3; r++) tick();
    enable = 1'b0;
    tick();
    check("t6_idle_state", int'(o_state),      0);
    check("t6_idle_dout",  int'(o_dout),       0);
    check("t6_idle_dv",    int'(o_dout_valid), 0);
    enable = 1'b1;
    mix_i  = '0;
    tick();
    check("t6_run_state", int'(o_state),      1);
    check("t6_ignored",   int'(o_dout_valid), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t6_dv%0d", i),  int'(o_dout_valid), 1);
      check($sformatf("t6_bit%0d", i), int'(o_dout),       exp_bit[i]);
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsm2_modulator.md
Name: dsm2_modulator

Overview:
- Second-order, 1-bit delta-sigma modulator: the stage directly downstream of the IQ mixer.
- Consumes the registered 15-bit signed mixer sum (Q1.14) on a sample strobe and emits one bitstream bit per accepted sample.
- Uses a Boser-Wooley topology (two half-gain integrators, sign quantizer) and adds overload detection with automatic integrator-reset recovery.

Parameters:
- IN_W, 15: input sample width, signed.
- ACC_W, 20: integrator width, signed, saturating.
- OVL_THRESH, 262144: |int2| >= OVL_THRESH counts as an overload sample.
- OVL_LIMIT, 8: consecutive overload samples that trigger RECOVER.
- RECOVER_LEN, 16: accepted samples spent in RECOVER.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  0 = IDLE (modulator held cleared).
- in_valid  in  1  sample strobe; mix_i is sampled when high.
- mix_i  in  IN_W  signed input sample.
- ovl_clr  in  1  clears ovl_sticky.
- dout  out  1  bitstream bit (1 = +FB, 0 = -FB).
- dout_valid  out  1  one-cycle pulse when dout updates.
- ovl_sticky  out  1  set when RECOVER is entered.
- state_o  out  2  current state (IDLE=0, RUN=1, RECOVER=2).

Behaviour:
- Reset is synchronous, active-high, on clock. Reset values: int1=int2=0, q=0, dout=0, dout_valid=0, ovl_sticky=0, ovl_cnt=0, rec_cnt=0, state=IDLE. Reset has priority over everything, including mid-RECOVER.
- Feedback: FB = 2^(IN_W-1) = 16384; fb = q ? +FB : -FB. x is mix_i sign-extended to ACC_W.
- RUN, in_valid=1, all from the registered old values:
  - int1 <= sat(int1 + ((x - fb) >>> 1))
  - int2 <= sat(int2 + ((int1 - fb) >>> 1))
  - q <= (int2_next + d) >= 0, where d = 0 unless dither is enabled.
- Saturation clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- dout = q. dout_valid = 1 in the cycle after each accepted strobe (latency 1).
- in_valid=0: all state is held and dout_valid=0.
- Overload counting (RUN only):
  - An accepted sample with |int2_next| >= OVL_THRESH increments ovl_cnt; any other accepted sample clears it.
  - When ovl_cnt would reach OVL_LIMIT: go to RECOVER, clear int1, int2 and ovl_cnt, set ovl_sticky. That sample's dout is still the computed q.
- RECOVER:
  - Each accepted strobe outputs the alternating pattern 1,0,1,0... (first bit 1), pulses dout_valid and increments rec_cnt.
  - Integrators stay at 0.
  - After RECOVER_LEN strobes: rec_cnt=0, q=0, go to RUN.
- IDLE: entered from any state when enable=0. Clears int1, int2, q and both counters; dout=0, no dout_valid. enable=1 moves IDLE->RUN in the next cycle, and strobes in that same cycle are ignored.
- ovl_sticky: ovl_clr clears it. If ovl_clr coincides with a RECOVER entry, set wins.

Optional Feature:
- Macro: DSM2_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset; advances once per accepted strobe in RUN.
  - d = $signed({1'b0, lfsr[3:0]}) - 8, range -8..+7, sign-extended to ACC_W; affects the quantizer decision only.
- Undefined: d = 0, no LFSR logic is present, and the bitstream is fully deterministic.

Decomposition:
- Package dsm_pkg: state enum (IDLE/RUN/RECOVER), FB constant, LFSR seed and tap constants.
- Sub-module dsm_sat_add: parameterised-width signed adder with saturation, instantiated twice for the integrators.

Test Plan:
1. Hold reset 3 cycles with in_valid=1 -> dout=0, dout_valid=0, ovl_sticky=0, state_o=0 throughout.
2. Zero-input start-up: enable=1, mix_i=0, in_valid every cycle, dither off -> first bits 1,1; int1/int2 after two samples = 0/4096; ones density over 1024 bits = 512±2.
3. mix_i=+8192 (0.5 FS), 4096 strobes -> ones density 75% ±1%. mix_i=-8192 -> 25% ±1%.
4. in_valid pulsed every 4th cycle -> exactly one dout_valid per strobe, 1 cycle later; integrators unchanged on gap cycles.
5. Overload run with OVL_THRESH=4096, mix_i=+16383 -> RECOVER entered after 8 consecutive overload samples; ovl_sticky=1; next 16 bits 1,0,1,0...; then state_o=1. Assert ovl_clr in the RECOVER-entry cycle -> ovl_sticky stays 1. Assert it one cycle later -> ovl_sticky clears.
6. Drop enable mid-RECOVER -> next cycle state_o=0, dout=0, no dout_valid. Re-enable with mix_i=0 -> bitstream restarts 1,1 exactly as in test 2.
